// File: rtl/pwr_pkg.sv
// Shared state encodings, counter width and per-state output decode for the
// power-domain wake scheduler.
package pwr_pkg;

   localparam int unsigned CNT_W                 = 8;
   localparam int unsigned DEFAULT_THERMAL_LIMIT = 85;

   localparam logic [2:0] ST_OFF    = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_PWR_UP = 3'd2;
   localparam logic [2:0] ST_CLK_ON = 3'd3;
   localparam logic [2:0] ST_ON     = 3'd4;
   localparam logic [2:0] ST_ISO    = 3'd5;

   typedef enum logic [2:0] {
      PWR_OFF    = ST_OFF,
      PWR_WAIT   = ST_WAIT,
      PWR_PWR_UP = ST_PWR_UP,
      PWR_CLK_ON = ST_CLK_ON,
      PWR_ON     = ST_ON,
      PWR_ISO    = ST_ISO
   } pwr_state_e;

   function automatic logic st_power(input logic [2:0] s);
      return (s == ST_PWR_UP) || (s == ST_CLK_ON) || (s == ST_ON) || (s == ST_ISO);
   endfunction

   function automatic logic st_clock(input logic [2:0] s);
      return (s == ST_CLK_ON) || (s == ST_ON);
   endfunction

   function automatic logic st_iso(input logic [2:0] s);
      return (s != ST_ON);
   endfunction

   function automatic logic st_ready(input logic [2:0] s);
      return (s == ST_ON);
   endfunction

   function automatic logic st_inflight(input logic [2:0] s);
      return (s == ST_PWR_UP) || (s == ST_CLK_ON);
   endfunction

   function automatic logic st_busy(input logic [2:0] s);
      return (s == ST_WAIT) || (s == ST_PWR_UP) || (s == ST_CLK_ON) || (s == ST_ISO);
   endfunction

endpackage

// File: rtl/pwr_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant when enabled; the pointer moves to
// winner+1 only when a grant is actually issued.
module pwr_rr_arbiter #(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] grant_o
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win;
   logic          found;

   always_comb begin
      found   = 1'b0;
      win     = '0;
      grant_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         int unsigned idx;
         idx = (32'(ptr_q) + i) % N;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      if (en_i && found) begin
         grant_o[win] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (en_i && found) begin
         ptr_d = (32'(win) == N - 1) ? '0 : win + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/power_domain_wake_scheduler.sv
// Per-domain power sequencing FSMs with a round-robin wake arbiter bounding
// concurrent power-ups. Optional thermal throttle: PWR_SCHED_THERMAL_THROTTLE_EN.
module power_domain_wake_scheduler
   import pwr_pkg::*;
#(
   parameter int unsigned NUM_DOMAINS         = 16,
   parameter int unsigned MAX_CONCURRENT_WAKE = 2,
   parameter int unsigned SETTLE_CYCLES       = 8,
   parameter int unsigned ISO_CYCLES          = 2
`ifdef PWR_SCHED_THERMAL_THROTTLE_EN
   ,parameter int unsigned THERMAL_LIMIT      = DEFAULT_THERMAL_LIMIT
`endif
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_DOMAINS-1:0]             wake_req,
   input  logic [NUM_DOMAINS-1:0]             sleep_req,
   input  logic                               dvfs_busy,
`ifdef PWR_SCHED_THERMAL_THROTTLE_EN
   input  logic [7:0]                         temperature,
`endif
   output logic [NUM_DOMAINS-1:0]             domain_power_enable,
   output logic [NUM_DOMAINS-1:0]             domain_clock_enable,
   output logic [NUM_DOMAINS-1:0]             domain_iso_enable,
   output logic [NUM_DOMAINS-1:0]             domain_ready,
   output logic [$clog2(NUM_DOMAINS+1)-1:0]   inflight_count,
   output logic                               busy
);

   localparam int unsigned N  = NUM_DOMAINS;
   localparam int unsigned CW = $clog2(NUM_DOMAINS + 1);

   logic [2:0]       state_q [N];
   logic [2:0]       state_d [N];
   logic [CNT_W-1:0] cnt_q   [N];
   logic [CNT_W-1:0] cnt_d   [N];

   logic [N-1:0]  power_q, power_d;
   logic [N-1:0]  clock_q, clock_d;
   logic [N-1:0]  iso_q,   iso_d;
   logic [N-1:0]  ready_q, ready_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic          busy_q, busy_d;

   logic [CW-1:0] limit;
   logic          grant_en;
   logic [N-1:0]  arb_req;
   logic [N-1:0]  arb_gnt;

`ifdef PWR_SCHED_THERMAL_THROTTLE_EN
   always_comb begin
      limit = (temperature >= 8'(THERMAL_LIMIT)) ? CW'(1) : CW'(MAX_CONCURRENT_WAKE);
   end
`else
   always_comb begin
      limit = CW'(MAX_CONCURRENT_WAKE);
   end
`endif

   // inflight_q mirrors the current registered state, so a slot freed by a
   // domain leaving CLK_ON becomes grantable one cycle later.
   assign grant_en = !dvfs_busy && (inflight_q < limit);

   // A WAIT domain that is cancelling this cycle must not consume the grant.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         arb_req[i] = (state_q[i] == ST_WAIT) && !sleep_req[i];
      end
   end

   pwr_rr_arbiter #(
      .N (N)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .en_i    (grant_en),
      .req_i   (arb_req),
      .grant_o (arb_gnt)
   );

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = '0;
         case (state_q[i])
            ST_OFF: begin
               if (wake_req[i]) state_d[i] = ST_WAIT;
            end
            ST_WAIT: begin
               if (sleep_req[i])    state_d[i] = ST_OFF;
               else if (arb_gnt[i]) state_d[i] = ST_PWR_UP;
            end
            ST_PWR_UP: begin
               if (cnt_q[i] == CNT_W'(SETTLE_CYCLES - 1)) state_d[i] = ST_CLK_ON;
               else                                       cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end
            ST_CLK_ON: begin
               state_d[i] = ST_ON;
            end
            ST_ON: begin
               if (sleep_req[i] && !wake_req[i]) state_d[i] = ST_ISO;
            end
            ST_ISO: begin
               if (cnt_q[i] == CNT_W'(ISO_CYCLES - 1)) state_d[i] = ST_OFF;
               else                                    cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end
            default: begin
               state_d[i] = ST_OFF;
            end
         endcase
      end
   end

   // Outputs are registered from next state so they change on the same edge as the state.
   always_comb begin
      power_d    = '0;
      clock_d    = '0;
      iso_d      = '0;
      ready_d    = '0;
      inflight_d = '0;
      busy_d     = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         power_d[i] = st_power(state_d[i]);
         clock_d[i] = st_clock(state_d[i]);
         iso_d[i]   = st_iso(state_d[i]);
         ready_d[i] = st_ready(state_d[i]);
         inflight_d = inflight_d + CW'(st_inflight(state_d[i]));
         busy_d     = busy_d | st_busy(state_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= ST_ON;
            cnt_q[i]   <= '0;
         end
         power_q    <= '1;
         clock_q    <= '1;
         iso_q      <= '0;
         ready_q    <= '1;
         inflight_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         power_q    <= power_d;
         clock_q    <= clock_d;
         iso_q      <= iso_d;
         ready_q    <= ready_d;
         inflight_q <= inflight_d;
         busy_q     <= busy_d;
      end
   end

   assign domain_power_enable = power_q;
   assign domain_clock_enable = clock_q;
   assign domain_iso_enable   = iso_q;
   assign domain_ready        = ready_q;
   assign inflight_count      = inflight_q;
   assign busy                = busy_q;

endmodule

// File: doc/power_domain_wake_scheduler.md
# power_domain_wake_scheduler

Sequences power-up and power-down of the NPU's PE power domains and rations concurrent wake-ups to bound inrush current. It sits between the domain-level power policy, which raises per-domain wake/sleep requests, and the physical power switches, clock gates and isolation cells. Each domain runs its own small FSM. A round-robin arbiter issues at most one wake grant per cycle. Grants are blocked while a DVFS transition is in progress.

## Interface
- NUM_DOMAINS, 16, number of power domains
- MAX_CONCURRENT_WAKE, 2, maximum domains allowed in PWR_UP or CLK_ON at the same time (1..NUM_DOMAINS)
- SETTLE_CYCLES, 8, cycles spent in PWR_UP after the power switch closes (≥1, ≤255)
- ISO_CYCLES, 2, cycles spent in ISO before power is removed (≥1, ≤15)
- THERMAL_LIMIT, 85, temperature code at or above which wake-up throttling applies (only with the macro)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wake_req  in  NUM_DOMAINS  level request to power a domain on
- sleep_req  in  NUM_DOMAINS  level request to power a domain off
- dvfs_busy  in  1  DVFS adjust/settle in progress; no new grants while high
- temperature  in  8  die temperature code (only with the macro)
- domain_power_enable  out  NUM_DOMAINS  power switch on
- domain_clock_enable  out  NUM_DOMAINS  clock un-gated
- domain_iso_enable  out  NUM_DOMAINS  isolation clamps active
- domain_ready  out  NUM_DOMAINS  domain fully on and usable
- inflight_count  out  $clog2(NUM_DOMAINS+1)  number of domains in PWR_UP or CLK_ON
- busy  out  1  any domain in WAIT, PWR_UP, CLK_ON or ISO

## Operation
- Per-domain states:
  - OFF: power 0, clock 0, iso 1, ready 0
  - WAIT: same outputs as OFF
  - PWR_UP: power 1, clock 0, iso 1
  - CLK_ON: power 1, clock 1, iso 1
  - ON: power 1, clock 1, iso 0, ready 1
  - ISO: power 1, clock 0, iso 1, ready 0
- Transitions:
  - OFF→WAIT on wake_req.
  - WAIT→PWR_UP on grant.
  - WAIT→OFF on sleep_req (the request is cancelled).
  - PWR_UP→CLK_ON after SETTLE_CYCLES cycles in PWR_UP.
  - CLK_ON→ON after 1 cycle.
  - ON→ISO on sleep_req & !wake_req.
  - ISO→OFF after ISO_CYCLES cycles in ISO.
- Ignored requests: sleep_req in PWR_UP or CLK_ON; wake_req in ISO. The domain re-enters WAIT from OFF if wake_req is still high.
- Grant rule: at most one grant per cycle. A grant requires dvfs_busy=0 and inflight_count < effective limit. The winner is the lowest WAIT index at or after the round-robin pointer, wrapping around. On a grant the pointer moves to winner+1 mod NUM_DOMAINS; otherwise it holds.
- Per-domain counters are 8-bit, cleared on state entry.
- inflight_count and busy are derived from registered state.
- dvfs_busy does not stall domains already in PWR_UP.

## Timing
- Reset: all domains ON, so power=1, clock=1, iso=0, ready=all ones. inflight_count=0, busy=0, pointer=0.
- Reset asserted mid-sequence forces every domain to ON on the next edge.
- All outputs are registered from state, so an output changes on the same edge as its state.
- Uncontended wake, counting from the edge that first samples wake_req=1 in OFF as edge 1:
  - WAIT after edge 1.
  - PWR_UP after edge 2, which raises power.
  - CLK_ON after edge 2+SETTLE_CYCLES.
  - ON and ready=1 after edge 3+SETTLE_CYCLES (edge 11 at defaults).
- Sleep: ISO (clock 0, iso 1, ready 0) one edge after sleep_req is sampled in ON; power drops ISO_CYCLES edges later.
- A freed in-flight slot is visible to the arbiter in the cycle after the domain leaves CLK_ON.

## Configuration
- PWR_SCHED_THERMAL_THROTTLE_EN defined:
  - The temperature port exists.
  - When temperature ≥ THERMAL_LIMIT, the effective limit is 1. Domains already in flight complete; they are not aborted.
- Undefined: no temperature port; the effective limit is MAX_CONCURRENT_WAKE.

## Structure
- Shared package pwr_pkg:
  - domain-state enum (OFF, WAIT, PWR_UP, CLK_ON, ON, ISO)
  - counter width constant
  - default THERMAL_LIMIT
- Sub-module pwr_rr_arbiter: N-way round-robin, one-hot grant, with an enable and a pointer-advance-on-grant rule.

## Test plan
- Reset, then sleep_req[3] pulsed → domain 3 iso=1/clock=0 after 1 edge, power=0 after 2 more; other domains untouched.
- All 16 domains OFF, wake_req all high at once, defaults → inflight_count never exceeds 2; grants go in index order 0,1,2,…; all domains ready by edge 16·(9)/2 + small tail.
- dvfs_busy held for 20 cycles with domain 5 in WAIT → no grant; grant on the first edge after dvfs_busy falls.
- Domain 7 in WAIT, sleep_req[7] high → returns to OFF next edge and never powers up.
- wake_req and sleep_req both high in ON → stays ON; wake_req raised during ISO → OFF, then WAIT, then a normal power-up.
- With the macro, temperature=90 and 4 domains waking → inflight_count ≤1; temperature drops to 80 → 2 in flight.
